// File: rtl/apb_fifo_slave.sv
// APB completer owning a small transmit FIFO. The master pushes words via
// APB writes to DATA; a hardware consumer drains them over valid/ready.
// CTRL/STATUS registers expose flush, overflow clear, interrupt enable,
// occupancy and a sticky overflow flag. WAIT_CYCLES inserts ACCESS wait states.
module apb_fifo_slave #(
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        o_valid,
    output logic [31:0] o_data,
    input  logic        o_ready,
    output logic        irq
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [2:0]      WAIT_LAST = 3'(WAIT_CYCLES);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t         state_q;
    state_t         state_nxt;
    state_t         phase;
    logic [2:0]     wait_q;
    logic [2:0]     wait_nxt;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           ovf_q;
    logic           ie_q;

    logic [2:0]     reg_idx;
    logic           commit;
    logic           wr_ctrl;
    logic           wr_data;
    logic           flush;
    logic           ovf_clr;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           ovf_set;
    logic [3:0]     cnt4;
    logic [31:0]    status;
    logic           unused_addr_bits;

    assign reg_idx          = PADDR[4:2];
    assign unused_addr_bits = ^{PADDR[31:5], PADDR[1:0]};

    // The transfer commits exactly once: the ACCESS cycle that raises PREADY.
    assign commit  = PSEL && PENABLE && PREADY;
    assign wr_ctrl = commit && PWRITE && (reg_idx == REG_CTRL);
    assign wr_data = commit && PWRITE && (reg_idx == REG_DATA);
    assign flush   = wr_ctrl && PWDATA[0];
    assign ovf_clr = wr_ctrl && PWDATA[1];

    // Full/empty come from the pre-cycle count, so a push at full is dropped
    // even when the consumer pops in the same cycle.
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign push    = wr_data && !full;
    assign ovf_set = wr_data && full;
    assign pop     = !empty && o_ready;

    assign o_valid = !empty;
    assign o_data  = empty ? 32'h0 : mem[rd_ptr_q];
    assign irq     = ie_q && (empty || ovf_q);

    assign cnt4    = 4'(count_q);
    assign status  = {24'h0, cnt4, 1'b0, ovf_q, full, empty};

    // Bus FSM state and wait-state counter.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
        end
    end

    // Next state and PREADY. The setup phase is recognised directly from IDLE
    // (PSEL && !PENABLE) so a zero-wait transfer completes in two cycles and
    // a new setup may immediately follow the PREADY cycle.
    always_comb begin
        state_nxt = state_q;
        wait_nxt  = wait_q;
        PREADY    = 1'b0;
        phase     = state_q;
        if (state_q == IDLE && PSEL && !PENABLE) begin
            phase = SETUP;
        end
        case (phase)
            IDLE: begin
                wait_nxt = 3'd0;
            end
            SETUP: begin
                wait_nxt  = 3'd0;
                state_nxt = PSEL ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                    wait_nxt  = 3'd0;
                end else if (wait_q == WAIT_LAST) begin
                    PREADY    = 1'b1;
                    state_nxt = IDLE;
                    wait_nxt  = 3'd0;
                end else begin
                    wait_nxt  = wait_q + 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = 3'd0;
            end
        endcase
    end

    // FIFO storage; contents need no reset because o_data is masked while empty.
    always_ff @(posedge PCLK) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= PWDATA;
        end
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Sticky overflow (set beats clear) and interrupt enable.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovf_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (wr_ctrl) begin
                ie_q <= PWDATA[2];
            end
        end
    end

    // Read mux; driven only during the access phase, zero otherwise.
    always_comb begin
        PRDATA = 32'h0;
        if (PSEL && PENABLE) begin
            case (reg_idx)
                REG_CTRL:   PRDATA[2] = ie_q;
                REG_STATUS: PRDATA    = status;
                REG_DATA:   PRDATA    = o_data;
                default:    PRDATA    = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Randomized bench for apb_fifo_slave: a queue-based reference model tracks
// the FIFO, overflow and IE, and every cycle's stream/irq/PREADY outputs and
// every read's PRDATA are compared against it. Two instances cover zero and
// three wait states.
module tb_apb_fifo_slave;

    localparam int DEPTH = 8;

    logic        PCLK   = 1'b0;
    logic        PRESET = 1'b1;
    logic [31:0] paddr  = 32'h0;
    logic [31:0] pwdata = 32'h0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic        psel   = 1'b0;
    logic        ordy   = 1'b0;
    int          cur    = 0;
    bit          rnd_rdy = 1'b0;

    logic        psel0, psel1, rdy0, rdy1;
    logic [31:0] prdata0, prdata1, odata0, odata1;
    logic        pready0, pready1, ovalid0, ovalid1, irq0, irq1;
    logic [31:0] prd, od;
    logic        prdy_c, ov, irq_c;

    logic [31:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_ie  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    assign psel0  = psel && (cur == 0);
    assign psel1  = psel && (cur == 1);
    assign rdy0   = ordy && (cur == 0);
    assign rdy1   = ordy && (cur == 1);
    assign prd    = (cur == 1) ? prdata1 : prdata0;
    assign od     = (cur == 1) ? odata1  : odata0;
    assign prdy_c = (cur == 1) ? pready1 : pready0;
    assign ov     = (cur == 1) ? ovalid1 : ovalid0;
    assign irq_c  = (cur == 1) ? irq1    : irq0;

    apb_fifo_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PWRITE(pwrite),
        .PENABLE(penable), .PSEL(psel0), .PWDATA(pwdata), .PRDATA(prdata0),
        .PREADY(pready0), .o_valid(ovalid0), .o_data(odata0), .o_ready(rdy0),
        .irq(irq0)
    );

    apb_fifo_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PWRITE(pwrite),
        .PENABLE(penable), .PSEL(psel1), .PWDATA(pwdata), .PRDATA(prdata1),
        .PREADY(pready1), .o_valid(ovalid1), .o_data(odata1), .o_ready(rdy1),
        .irq(irq1)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] s;
        logic [2:0]  idx;
        s   = 32'h0;
        idx = a[4:2];
        case (idx)
            3'd0: s[2] = m_ie;
            3'd1: begin
                s[0]   = (q.size() == 0);
                s[1]   = (q.size() == DEPTH);
                s[2]   = m_ovf;
                s[7:4] = 4'(q.size());
            end
            3'd2: s = (q.size() != 0) ? q[0] : 32'h0;
            default: s = 32'h0;
        endcase
        return s;
    endfunction

    function automatic void model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_ie  = 1'b0;
    endfunction

    // One clock: check outputs at negedge, then advance the model at posedge.
    task automatic cycle(input bit exp_rdy, input bit commit, output logic [31:0] rd);
        bit          pop, push, ovf_set, flush, clr, ie_wr;
        logic [2:0]  idx;
        logic [31:0] w;
        @(negedge PCLK);
        chk("o_valid", 32'(ov), 32'(q.size() != 0));
        chk("o_data", od, (q.size() != 0) ? q[0] : 32'h0);
        chk("irq", 32'(irq_c), 32'(m_ie && (q.size() == 0 || m_ovf)));
        chk("pready", 32'(prdy_c), 32'(exp_rdy));
        rd = prd;
        if (commit && !pwrite) chk("prdata", prd, model_read(paddr));
        idx     = paddr[4:2];
        w       = pwdata;
        pop     = (q.size() != 0) && ordy;
        push    = 1'b0;
        ovf_set = 1'b0;
        flush   = 1'b0;
        clr     = 1'b0;
        ie_wr   = 1'b0;
        if (commit && pwrite && idx == 3'd0) begin
            flush = w[0];
            clr   = w[1];
            ie_wr = 1'b1;
        end
        if (commit && pwrite && idx == 3'd2) begin
            if (q.size() == DEPTH) ovf_set = 1'b1;
            else push = 1'b1;
        end
        @(posedge PCLK);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(w);
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (ie_wr) m_ie = w[2];
        #1;
        if (rnd_rdy) ordy = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        logic [31:0] tmp;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, tmp);
    endtask

    task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        int          wl;
        logic [31:0] tmp;
        wl      = (cur == 1) ? 3 : 0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        cycle(1'b0, 1'b0, tmp);
        penable = 1'b1;
        rd = 32'h0;
        for (int i = 0; i <= wl; i++) cycle(i == wl, i == wl, rd);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic do_reset();
        PRESET  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        ordy    = 1'b0;
        model_clear();
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] tmp;
        logic [31:0] a, d;
        int          r;

        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_pready", 32'(pready0), 32'h0);
        chk("rst_o_valid", 32'(ovalid0), 32'h0);
        chk("rst_o_data", odata0, 32'h0);
        chk("rst_irq", 32'(irq0), 32'h0);
        chk("rst_prdata", prdata0, 32'h0);
        PRESET = 1'b0;

        // Fill to full with the consumer stalled, then overflow once.
        apb(1'b0, 32'h1000_3004, 32'h0, rd);
        chk("status_reset", rd, 32'h0000_0001);
        for (int i = 1; i <= 8; i++) apb(1'b1, 32'h1000_3008, 32'hA5A5_0000 + i, rd);
        apb(1'b0, 32'h1000_3004, 32'h0, rd);
        chk("status_full", rd, 32'h0000_0082);
        apb(1'b1, 32'h1000_3008, 32'hA5A5_0009, rd);
        apb(1'b0, 32'h1000_3004, 32'h0, rd);
        chk("status_ovf", rd, 32'h0000_0086);
        apb(1'b1, 32'h1000_3000, 32'h4, rd);
        idle(1);
        chk("irq_ovf", 32'(irq0), 32'h1);

        // Drain one word per cycle, in push order.
        ordy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain", odata0, 32'hA5A5_0000 + i);
            cycle(1'b0, 1'b0, tmp);
        end
        chk("drained_valid", 32'(ovalid0), 32'h0);
        ordy = 1'b0;
        apb(1'b1, 32'h1000_3000, 32'h2, rd);
        apb(1'b0, 32'h1000_3004, 32'h0, rd);
        chk("status_ovf_clr", rd, 32'h0000_0001);

        // Flush while the consumer is popping.
        for (int i = 0; i < 3; i++) apb(1'b1, 32'h1000_3008, 32'hBEEF_0000 + i, rd);
        ordy = 1'b1;
        apb(1'b1, 32'h1000_3000, 32'h1, rd);
        ordy = 1'b0;
        chk("flush_valid", 32'(ovalid0), 32'h0);
        apb(1'b0, 32'h1000_3008, 32'h0, rd);
        chk("flush_data", rd, 32'h0);

        // Random traffic with a toggling consumer.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 120; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
                apb(1'b1, ($urandom & 32'hFFFF_FFE3) | 32'h8, $urandom, rd);
            end else if (r <= 6) begin
                a = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
                apb(1'b0, a, 32'h0, rd);
            end else if (r == 7) begin
                d = 32'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
                apb(1'b1, ($urandom & 32'hFFFF_FFE3), d, rd);
            end else if (r == 8) begin
                apb(1'b1, ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(3, 7)) << 2), $urandom, rd);
            end else begin
                idle(int'($urandom_range(0, 3)));
            end
        end
        rnd_rdy = 1'b0;
        ordy    = 1'b0;
        idle(1);

        // Three wait states: PREADY timing is checked every cycle by apb().
        cur = 1;
        do_reset();
        apb(1'b1, 32'h1000_3008, 32'hCAFE_0001, rd);
        apb(1'b0, 32'h1000_3004, 32'h0, rd);
        chk("status_wait3", rd, 32'h0000_0010);
        apb(1'b1, 32'h1000_3000, 32'h4, rd);
        apb(1'b1, 32'h1000_3008, 32'hCAFE_0002, rd);

        // Reset asserted on the would-be commit cycle: transfer lost.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h1000_3008;
        pwdata  = 32'hCAFE_0003;
        cycle(1'b0, 1'b0, tmp);
        penable = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, tmp);
        #1;
        chk("pre_rst_pready", 32'(pready1), 32'h1);
        PRESET = 1'b1;
        #1;
        chk("midrst_pready", 32'(pready1), 32'h0);
        chk("midrst_o_valid", 32'(ovalid1), 32'h0);
        chk("midrst_o_data", odata1, 32'h0);
        chk("midrst_irq", 32'(irq1), 32'h0);
        paddr = 32'h1000_3004;
        #1;
        chk("midrst_status", prdata1, 32'h0000_0001);
        psel    = 1'b0;
        penable = 1'b0;
        model_clear();
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        idle(2);
        apb(1'b0, 32'h1000_3004, 32'h0, rd);
        chk("post_rst_status", rd, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
